// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit.
// A Moore FSM steps each instruction (lw, sw, R-type, I-type ALU, beq, jal)
// through fetch/decode/execute/memory/writeback using one shared memory and
// one ALU. It also handles memory wait states, traps illegal opcodes and
// counts retired instructions.
module multicycle_controller #(
  parameter int CNT_W      = 32,
  parameter bit MEM_STALL  = 1'b1,
  parameter bit ENABLE_JAL = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic             i_funct7bit5,
  input  logic             i_zero,
  input  logic             i_memReady,
  output logic             o_pcWriteEn,
  output logic             o_irWriteEn,
  output logic             o_adrSrc,
  output logic             o_memWriteEn,
  output logic             o_regWriteEn,
  output logic [1:0]       o_resultSrc,
  output logic [1:0]       o_aluSrcA,
  output logic [1:0]       o_aluSrcB,
  output logic [3:0]       o_aluLogicOperation,
  output logic [2:0]       o_immSrc,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired
);

  // Major opcodes understood by this controller.
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // ALU operation codes used directly by the sequencer.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // Datapath select encodings.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  state_t           stateReg;
  state_t           stateNext;
  logic             jalPendReg;
  logic             illegalReg;
  logic [CNT_W-1:0] retiredReg;

  logic       memReadyEff;
  logic       isLoad;
  logic       isStore;
  logic       isRType;
  logic       isIAlu;
  logic       isBeq;
  logic       isJal;
  logic       retire;
  logic       pcWe;
  logic       irWe;
  logic       adrSel;
  logic       memWe;
  logic       regWe;
  logic [1:0] resultSel;
  logic [1:0] srcASel;
  logic [1:0] srcBSel;
  logic [3:0] aluOp;
  logic [2:0] immSel;

  // With stalling disabled the memory is assumed to finish every access in one cycle.
  assign memReadyEff = (MEM_STALL != 1'b0) ? i_memReady : 1'b1;

  assign isLoad  = (i_opcode == OP_LW);
  assign isStore = (i_opcode == OP_SW);
  assign isRType = (i_opcode == OP_R);
  assign isIAlu  = (i_opcode == OP_IALU);
  assign isBeq   = (i_opcode == OP_BEQ);
  // When jal support is built out, the jal opcode falls through to the trap.
  assign isJal   = (ENABLE_JAL != 1'b0) && (i_opcode == OP_JAL);

  // State register; reset parks the machine in FETCH.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      stateReg <= FETCH;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Remembers that the ALUWB about to run belongs to a jal that already retired.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      jalPendReg <= 1'b0;
    end else begin
      jalPendReg <= (stateReg == JAL);
    end
  end

  // Sticky illegal flag, raised on the edge that enters TRAP.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      illegalReg <= 1'b0;
    end else if (stateNext == TRAP) begin
      illegalReg <= 1'b1;
    end
  end

  // Retired-instruction counter, one increment per completed instruction, wrapping.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      retiredReg <= '0;
    end else if (retire) begin
      retiredReg <= retiredReg + CNT_W'(1);
    end
  end

  // Next-state and per-state datapath controls (Moore, apart from ready/zero qualifiers).
  always_comb begin
    stateNext = stateReg;
    pcWe      = 1'b0;
    irWe      = 1'b0;
    adrSel    = 1'b0;
    memWe     = 1'b0;
    regWe     = 1'b0;
    resultSel = RES_ALUOUT;
    srcASel   = SRCA_PC;
    srcBSel   = SRCB_RS2;
    aluOp     = ALU_ADD;
    retire    = 1'b0;
    case (stateReg)
      FETCH: begin
        // PC + 4 goes straight back to the PC through the ALU result path.
        adrSel    = 1'b0;
        srcASel   = SRCA_PC;
        srcBSel   = SRCB_FOUR;
        aluOp     = ALU_ADD;
        resultSel = RES_ALU;
        if (memReadyEff) begin
          irWe      = 1'b1;
          pcWe      = 1'b1;
          stateNext = DECODE;
        end
      end
      DECODE: begin
        // Speculatively compute the branch/jump target oldPC + imm.
        srcASel = SRCA_OLDPC;
        srcBSel = SRCB_IMM;
        aluOp   = ALU_ADD;
        if (isLoad || isStore) begin
          stateNext = MEMADR;
        end else if (isRType) begin
          stateNext = EXEC_R;
        end else if (isIAlu) begin
          stateNext = EXEC_I;
        end else if (isBeq) begin
          stateNext = BEQ;
        end else if (isJal) begin
          stateNext = JAL;
        end else begin
          stateNext = TRAP;
        end
      end
      MEMADR: begin
        srcASel   = SRCA_RS1;
        srcBSel   = SRCB_IMM;
        aluOp     = ALU_ADD;
        stateNext = isLoad ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrSel    = 1'b1;
        resultSel = RES_ALUOUT;
        if (memReadyEff) begin
          stateNext = MEMWB;
        end
      end
      MEMWB: begin
        resultSel = RES_RDATA;
        regWe     = 1'b1;
        retire    = 1'b1;
        stateNext = FETCH;
      end
      MEMWRITE: begin
        // Write strobe stays up for the whole wait-state stretch.
        adrSel = 1'b1;
        memWe  = 1'b1;
        if (memReadyEff) begin
          retire    = 1'b1;
          stateNext = FETCH;
        end
      end
      EXEC_R: begin
        srcASel   = SRCA_RS1;
        srcBSel   = SRCB_RS2;
        aluOp     = {i_funct7bit5, i_funct3};
        stateNext = ALUWB;
      end
      EXEC_I: begin
        // Only the shift-right group uses bit 30 (srli/srai); elsewhere it is immediate data.
        srcASel   = SRCA_RS1;
        srcBSel   = SRCB_IMM;
        aluOp     = (i_funct3 == 3'b101) ? {i_funct7bit5, i_funct3} : {1'b0, i_funct3};
        stateNext = ALUWB;
      end
      ALUWB: begin
        resultSel = RES_ALUOUT;
        regWe     = 1'b1;
        retire    = !jalPendReg;
        stateNext = FETCH;
      end
      BEQ: begin
        // ALUOut holds the target from DECODE; load it only when rs1 == rs2.
        srcASel   = SRCA_RS1;
        srcBSel   = SRCB_RS2;
        aluOp     = ALU_SUB;
        resultSel = RES_ALUOUT;
        pcWe      = i_zero;
        retire    = 1'b1;
        stateNext = FETCH;
      end
      JAL: begin
        // PC <- target in ALUOut while the ALU forms the link value oldPC + 4.
        srcASel   = SRCA_OLDPC;
        srcBSel   = SRCB_FOUR;
        aluOp     = ALU_ADD;
        resultSel = RES_ALUOUT;
        pcWe      = 1'b1;
        retire    = 1'b1;
        stateNext = ALUWB;
      end
      TRAP: begin
        stateNext = TRAP;
      end
      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    immSel = 3'b000;
    case (i_opcode)
      OP_LW:   immSel = 3'b000;
      OP_IALU: immSel = 3'b000;
      OP_SW:   immSel = 3'b001;
      OP_BEQ:  immSel = 3'b010;
      OP_JAL:  immSel = 3'b011;
      default: immSel = 3'b000;
    endcase
  end

  // Write enables are cut off combinationally the moment reset rises.
  assign o_pcWriteEn         = pcWe  & ~i_arst;
  assign o_irWriteEn         = irWe  & ~i_arst;
  assign o_memWriteEn        = memWe & ~i_arst;
  assign o_regWriteEn        = regWe & ~i_arst;
  assign o_adrSrc            = adrSel;
  assign o_resultSrc         = resultSel;
  assign o_aluSrcA           = srcASel;
  assign o_aluSrcB           = srcBSel;
  assign o_aluLogicOperation = aluOp;
  assign o_immSrc            = immSel;
  assign o_illegal           = illegalReg;
  assign o_retired           = retiredReg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle vector table for the
// default build, plus hand sequences on a CNT_W=4 / ENABLE_JAL=0 build.
module tb_multicycle_controller;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IALU = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic        clk = 1'b0;
  logic        arst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7bit5;
  logic        zero;
  logic        memReady;

  logic        pcWe, irWe, adrSrc, memWe, regWe, illegal;
  logic [1:0]  resultSrc, aluSrcA, aluSrcB;
  logic [3:0]  aluOp;
  logic [2:0]  immSrc;
  logic [31:0] retired;

  logic        bArst;
  logic [6:0]  bOpcode;
  logic        bPcWe, bIrWe, bAdrSrc, bMemWe, bRegWe, bIllegal;
  logic [1:0]  bResultSrc, bAluSrcA, bAluSrcB;
  logic [3:0]  bAluOp;
  logic [2:0]  bImmSrc;
  logic [3:0]  bRetired;

  logic [17:0] ctlMain;
  logic [17:0] ctlB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .i_clk(clk), .i_arst(arst), .i_opcode(opcode), .i_funct3(funct3),
    .i_funct7bit5(funct7bit5), .i_zero(zero), .i_memReady(memReady),
    .o_pcWriteEn(pcWe), .o_irWriteEn(irWe), .o_adrSrc(adrSrc),
    .o_memWriteEn(memWe), .o_regWriteEn(regWe), .o_resultSrc(resultSrc),
    .o_aluSrcA(aluSrcA), .o_aluSrcB(aluSrcB), .o_aluLogicOperation(aluOp),
    .o_immSrc(immSrc), .o_illegal(illegal), .o_retired(retired)
  );

  multicycle_controller #(.CNT_W(4), .MEM_STALL(1'b1), .ENABLE_JAL(1'b0)) dutB (
    .i_clk(clk), .i_arst(bArst), .i_opcode(bOpcode), .i_funct3(funct3),
    .i_funct7bit5(funct7bit5), .i_zero(zero), .i_memReady(memReady),
    .o_pcWriteEn(bPcWe), .o_irWriteEn(bIrWe), .o_adrSrc(bAdrSrc),
    .o_memWriteEn(bMemWe), .o_regWriteEn(bRegWe), .o_resultSrc(bResultSrc),
    .o_aluSrcA(bAluSrcA), .o_aluSrcB(bAluSrcB), .o_aluLogicOperation(bAluOp),
    .o_immSrc(bImmSrc), .o_illegal(bIllegal), .o_retired(bRetired)
  );

  assign ctlMain = {pcWe, irWe, adrSrc, memWe, regWe, resultSrc, aluSrcA, aluSrcB, aluOp, immSrc};
  assign ctlB    = {bPcWe, bIrWe, bAdrSrc, bMemWe, bRegWe, bResultSrc, bAluSrcA, bAluSrcB, bAluOp, bImmSrc};

  typedef struct {
    string       name;
    logic        arst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic        zero;
    logic        rdy;
    logic [17:0] ctl;
    logic        ill;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] mk(input logic pc, input logic ir, input logic adr,
                                     input logic mw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [3:0] op, input logic [2:0] imm);
    return {pc, ir, adr, mw, rw, rs, a, b, op, imm};
  endfunction

  // Hand-written expected control words per state.
  function automatic logic [17:0] wFetch(input logic [2:0] imm);
    return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 4'b0000, imm);
  endfunction
  function automatic logic [17:0] wFetchIdle(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 4'b0000, imm);
  endfunction
  function automatic logic [17:0] wDec(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 4'b0000, imm);
  endfunction
  function automatic logic [17:0] wMemAdr(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 4'b0000, imm);
  endfunction
  function automatic logic [17:0] wExR(input logic [3:0] op);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, op, 3'b000);
  endfunction
  function automatic logic [17:0] wExI(input logic [3:0] op);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, op, 3'b000);
  endfunction
  function automatic logic [17:0] wAluWb(input logic [2:0] imm);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, imm);
  endfunction
  function automatic logic [17:0] wBeq(input logic pc);
    return mk(pc, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 4'b1000, 3'b010);
  endfunction

  localparam logic [17:0] W_MEMRD = 18'b0_0_1_0_0_00_00_00_0000_000;
  localparam logic [17:0] W_MEMWB = 18'b0_0_0_0_1_01_00_00_0000_000;
  localparam logic [17:0] W_MEMWR = 18'b0_0_1_1_0_00_00_00_0000_001;
  localparam logic [17:0] W_JAL   = 18'b1_0_0_0_0_00_01_10_0000_011;
  localparam logic [17:0] W_TRAP  = 18'b0_0_0_0_0_00_00_00_0000_000;

  task automatic add(input string nm, input logic ar, input logic [6:0] opc,
                     input logic [2:0] f3, input logic f7, input logic z, input logic rdy,
                     input logic [17:0] ctl, input logic ill, input logic [31:0] ret);
    vec_t v;
    v.name = nm; v.arst = ar; v.opc = opc; v.f3 = f3; v.f7 = f7;
    v.zero = z; v.rdy = rdy; v.ctl = ctl; v.ill = ill; v.ret = ret;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Stop a runaway simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst = 1'b1; bArst = 1'b1;
    opcode = LW; bOpcode = BEQ;
    funct3 = 3'b000; funct7bit5 = 1'b0; zero = 1'b0; memReady = 1'b1;

    // ---- vector table for the default build ----
    add("reset",        1'b1, LW,   3'b000, 1'b0, 1'b0, 1'b1, wFetchIdle(3'b000), 1'b0, 32'd0);
    add("lw.fetch",     1'b0, LW,   3'b010, 1'b0, 1'b0, 1'b1, wFetch(3'b000),     1'b0, 32'd0);
    add("lw.decode",    1'b0, LW,   3'b010, 1'b0, 1'b0, 1'b1, wDec(3'b000),       1'b0, 32'd0);
    add("lw.memadr",    1'b0, LW,   3'b010, 1'b0, 1'b0, 1'b1, wMemAdr(3'b000),    1'b0, 32'd0);
    add("lw.memread",   1'b0, LW,   3'b010, 1'b0, 1'b0, 1'b1, W_MEMRD,            1'b0, 32'd0);
    add("lw.memwb",     1'b0, LW,   3'b010, 1'b0, 1'b0, 1'b1, W_MEMWB,            1'b0, 32'd0);
    add("sw.fetch",     1'b0, SW,   3'b010, 1'b0, 1'b0, 1'b1, wFetch(3'b001),     1'b0, 32'd1);
    add("sw.decode",    1'b0, SW,   3'b010, 1'b0, 1'b0, 1'b1, wDec(3'b001),       1'b0, 32'd1);
    add("sw.memadr",    1'b0, SW,   3'b010, 1'b0, 1'b0, 1'b1, wMemAdr(3'b001),    1'b0, 32'd1);
    add("sw.wait1",     1'b0, SW,   3'b010, 1'b0, 1'b0, 1'b0, W_MEMWR,            1'b0, 32'd1);
    add("sw.wait2",     1'b0, SW,   3'b010, 1'b0, 1'b0, 1'b0, W_MEMWR,            1'b0, 32'd1);
    add("sw.wait3",     1'b0, SW,   3'b010, 1'b0, 1'b0, 1'b0, W_MEMWR,            1'b0, 32'd1);
    add("sw.memwrite",  1'b0, SW,   3'b010, 1'b0, 1'b0, 1'b1, W_MEMWR,            1'b0, 32'd1);
    add("add.stall",    1'b0, RT,   3'b000, 1'b0, 1'b0, 1'b0, wFetchIdle(3'b000), 1'b0, 32'd2);
    add("add.fetch",    1'b0, RT,   3'b000, 1'b0, 1'b0, 1'b1, wFetch(3'b000),     1'b0, 32'd2);
    add("add.decode",   1'b0, RT,   3'b000, 1'b0, 1'b0, 1'b1, wDec(3'b000),       1'b0, 32'd2);
    add("add.exec",     1'b0, RT,   3'b000, 1'b0, 1'b0, 1'b1, wExR(4'b0000),      1'b0, 32'd2);
    add("add.aluwb",    1'b0, RT,   3'b000, 1'b0, 1'b0, 1'b1, wAluWb(3'b000),     1'b0, 32'd2);
    add("sub.fetch",    1'b0, RT,   3'b000, 1'b1, 1'b0, 1'b1, wFetch(3'b000),     1'b0, 32'd3);
    add("sub.decode",   1'b0, RT,   3'b000, 1'b1, 1'b0, 1'b1, wDec(3'b000),       1'b0, 32'd3);
    add("sub.exec",     1'b0, RT,   3'b000, 1'b1, 1'b0, 1'b1, wExR(4'b1000),      1'b0, 32'd3);
    add("sub.aluwb",    1'b0, RT,   3'b000, 1'b1, 1'b0, 1'b1, wAluWb(3'b000),     1'b0, 32'd3);
    add("addi.fetch",   1'b0, IALU, 3'b000, 1'b1, 1'b0, 1'b1, wFetch(3'b000),     1'b0, 32'd4);
    add("addi.decode",  1'b0, IALU, 3'b000, 1'b1, 1'b0, 1'b1, wDec(3'b000),       1'b0, 32'd4);
    add("addi.exec",    1'b0, IALU, 3'b000, 1'b1, 1'b0, 1'b1, wExI(4'b0000),      1'b0, 32'd4);
    add("addi.aluwb",   1'b0, IALU, 3'b000, 1'b1, 1'b0, 1'b1, wAluWb(3'b000),     1'b0, 32'd4);
    add("xori.fetch",   1'b0, IALU, 3'b100, 1'b1, 1'b0, 1'b1, wFetch(3'b000),     1'b0, 32'd5);
    add("xori.decode",  1'b0, IALU, 3'b100, 1'b1, 1'b0, 1'b1, wDec(3'b000),       1'b0, 32'd5);
    add("xori.exec",    1'b0, IALU, 3'b100, 1'b1, 1'b0, 1'b1, wExI(4'b0100),      1'b0, 32'd5);
    add("xori.aluwb",   1'b0, IALU, 3'b100, 1'b1, 1'b0, 1'b1, wAluWb(3'b000),     1'b0, 32'd5);
    add("srai.fetch",   1'b0, IALU, 3'b101, 1'b1, 1'b0, 1'b1, wFetch(3'b000),     1'b0, 32'd6);
    add("srai.decode",  1'b0, IALU, 3'b101, 1'b1, 1'b0, 1'b1, wDec(3'b000),       1'b0, 32'd6);
    add("srai.exec",    1'b0, IALU, 3'b101, 1'b1, 1'b0, 1'b1, wExI(4'b1101),      1'b0, 32'd6);
    add("srai.aluwb",   1'b0, IALU, 3'b101, 1'b1, 1'b0, 1'b1, wAluWb(3'b000),     1'b0, 32'd6);
    add("beqT.fetch",   1'b0, BEQ,  3'b000, 1'b0, 1'b1, 1'b1, wFetch(3'b010),     1'b0, 32'd7);
    add("beqT.decode",  1'b0, BEQ,  3'b000, 1'b0, 1'b1, 1'b1, wDec(3'b010),       1'b0, 32'd7);
    add("beqT.beq",     1'b0, BEQ,  3'b000, 1'b0, 1'b1, 1'b1, wBeq(1'b1),         1'b0, 32'd7);
    add("beqN.fetch",   1'b0, BEQ,  3'b000, 1'b0, 1'b0, 1'b1, wFetch(3'b010),     1'b0, 32'd8);
    add("beqN.decode",  1'b0, BEQ,  3'b000, 1'b0, 1'b0, 1'b1, wDec(3'b010),       1'b0, 32'd8);
    add("beqN.beq",     1'b0, BEQ,  3'b000, 1'b0, 1'b0, 1'b1, wBeq(1'b0),         1'b0, 32'd8);
    add("jal.fetch",    1'b0, JAL,  3'b000, 1'b0, 1'b0, 1'b1, wFetch(3'b011),     1'b0, 32'd9);
    add("jal.decode",   1'b0, JAL,  3'b000, 1'b0, 1'b0, 1'b1, wDec(3'b011),       1'b0, 32'd9);
    add("jal.jal",      1'b0, JAL,  3'b000, 1'b0, 1'b0, 1'b1, W_JAL,              1'b0, 32'd9);
    add("jal.aluwb",    1'b0, JAL,  3'b000, 1'b0, 1'b0, 1'b1, wAluWb(3'b011),     1'b0, 32'd10);
    add("addi2.fetch",  1'b0, IALU, 3'b000, 1'b0, 1'b0, 1'b1, wFetch(3'b000),     1'b0, 32'd10);
    add("addi2.decode", 1'b0, IALU, 3'b000, 1'b0, 1'b0, 1'b1, wDec(3'b000),       1'b0, 32'd10);
    add("addi2.exec",   1'b0, IALU, 3'b000, 1'b0, 1'b0, 1'b1, wExI(4'b0000),      1'b0, 32'd10);
    add("addi2.aluwb",  1'b0, IALU, 3'b000, 1'b0, 1'b0, 1'b1, wAluWb(3'b000),     1'b0, 32'd10);
    add("bad.fetch",    1'b0, BAD,  3'b000, 1'b0, 1'b0, 1'b1, wFetch(3'b000),     1'b0, 32'd11);
    add("bad.decode",   1'b0, BAD,  3'b000, 1'b0, 1'b0, 1'b1, wDec(3'b000),       1'b0, 32'd11);
    add("bad.trap1",    1'b0, BAD,  3'b000, 1'b0, 1'b1, 1'b1, W_TRAP,             1'b1, 32'd11);
    add("bad.trap2",    1'b0, BAD,  3'b000, 1'b0, 1'b1, 1'b1, W_TRAP,             1'b1, 32'd11);
    add("bad.trap3",    1'b0, BAD,  3'b000, 1'b0, 1'b1, 1'b1, W_TRAP,             1'b1, 32'd11);
    add("trap.reset",   1'b1, IALU, 3'b000, 1'b0, 1'b0, 1'b1, wFetchIdle(3'b000), 1'b0, 32'd0);
    add("addi3.fetch",  1'b0, IALU, 3'b000, 1'b0, 1'b0, 1'b1, wFetch(3'b000),     1'b0, 32'd0);
    add("addi3.decode", 1'b0, IALU, 3'b000, 1'b0, 1'b0, 1'b1, wDec(3'b000),       1'b0, 32'd0);
    add("addi3.exec",   1'b0, IALU, 3'b000, 1'b0, 1'b0, 1'b1, wExI(4'b0000),      1'b0, 32'd0);
    add("addi3.aluwb",  1'b0, IALU, 3'b000, 1'b0, 1'b0, 1'b1, wAluWb(3'b000),     1'b0, 32'd0);
    add("sw2.fetch",    1'b0, SW,   3'b010, 1'b0, 1'b0, 1'b1, wFetch(3'b001),     1'b0, 32'd1);
    add("sw2.decode",   1'b0, SW,   3'b010, 1'b0, 1'b0, 1'b1, wDec(3'b001),       1'b0, 32'd1);
    add("sw2.memadr",   1'b0, SW,   3'b010, 1'b0, 1'b0, 1'b1, wMemAdr(3'b001),    1'b0, 32'd1);
    add("sw2.wait",     1'b0, SW,   3'b010, 1'b0, 1'b0, 1'b0, W_MEMWR,            1'b0, 32'd1);
    add("sw2.abort",    1'b1, SW,   3'b010, 1'b0, 1'b0, 1'b0, wFetchIdle(3'b001), 1'b0, 32'd0);
    add("post.fetch",   1'b0, SW,   3'b010, 1'b0, 1'b0, 1'b1, wFetch(3'b001),     1'b0, 32'd0);
    add("post.decode",  1'b0, SW,   3'b010, 1'b0, 1'b0, 1'b1, wDec(3'b001),       1'b0, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      arst       = vecs[i].arst;
      opcode     = vecs[i].opc;
      funct3     = vecs[i].f3;
      funct7bit5 = vecs[i].f7;
      zero       = vecs[i].zero;
      memReady   = vecs[i].rdy;
      @(negedge clk);
      $display("vec %0d %s ctl=%05h illegal=%0b retired=%0d", i, vecs[i].name, ctlMain, illegal, retired);
      check({vecs[i].name, ".ctl"}, 32'(ctlMain), 32'(vecs[i].ctl));
      check({vecs[i].name, ".illegal"}, 32'(illegal), 32'(vecs[i].ill));
      check({vecs[i].name, ".retired"}, retired, vecs[i].ret);
      @(posedge clk);
      #1;
    end

    // ---- narrow counter wrap on the CNT_W=4 build ----
    funct3 = 3'b000; funct7bit5 = 1'b0; zero = 1'b0; memReady = 1'b1;
    @(negedge clk);
    check("B.reset.retired", 32'(bRetired), 32'd0);
    check("B.reset.illegal", 32'(bIllegal), 32'd0);
    @(posedge clk);
    #1;
    bArst = 1'b0;
    bOpcode = BEQ;
    for (int i = 0; i < 16; i++) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("B beq %0d retired=%0d", i, bRetired);
      check("B.retired", 32'(bRetired), 32'((i + 1) % 16));
    end

    // ---- jal is illegal when built out ----
    bOpcode = JAL;
    zero = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      $display("B trap cycle %0d ctl=%05h illegal=%0b", i, ctlB, bIllegal);
      check("B.trap.illegal", 32'(bIllegal), 32'd1);
      check("B.trap.ctl", 32'(ctlB), 32'(18'b0_0_0_0_0_00_00_00_0000_011));
      check("B.trap.retired", 32'(bRetired), 32'd0);
    end
    @(posedge clk);
    #1;
    bArst = 1'b1;
    @(negedge clk);
    check("B.trapreset.illegal", 32'(bIllegal), 32'd0);
    check("B.trapreset.we", 32'({bPcWe, bIrWe, bMemWe, bRegWe}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle successor to the single-cycle instruction decoder. A Moore FSM sequences each RV32I instruction (lw, sw, R-type, I-type ALU, beq, jal) over 3-5 cycles through one shared memory and one ALU, and drives all datapath select/enable lines. It adds memory wait-state handshaking, an illegal-opcode trap and a retired-instruction counter. It sits beside the multicycle datapath, fed by the instruction register.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).
MEM_STALL, 1, 1: honour i_memReady; 0: treat i_memReady as constant 1.
ENABLE_JAL, 1, 0: the jal opcode is decoded as illegal.

Ports:
i_clk  in  1  clock
i_arst  in  1  asynchronous active-high reset
i_opcode  in  7  instruction register bits [6:0]
i_funct3  in  3  instruction register bits [14:12]
i_funct7bit5  in  1  instruction register bit 30
i_zero  in  1  ALU zero flag
i_memReady  in  1  memory access completes this cycle
o_pcWriteEn  out  1  PC register load
o_irWriteEn  out  1  instruction register and oldPC load
o_adrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
o_memWriteEn  out  1  data memory write
o_regWriteEn  out  1  register file write
o_resultSrc  out  2  result select: 00 = ALUOut, 01 = read data, 10 = ALU result
o_aluSrcA  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1
o_aluSrcB  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4
o_aluLogicOperation  out  4  ALU operation; ADD = 4'b0000, SUB = 4'b1000
o_immSrc  out  3  immediate format: I = 000, S = 001, B = 010, J = 011
o_illegal  out  1  sticky illegal-opcode flag
o_retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (i_arst high, asynchronous): state = FETCH, o_illegal = 0, o_retired = 0. All write enables (pc, ir, mem, reg) are forced to 0 while i_arst is high. The first fetch occurs in the first cycle after deassertion.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- Unlisted selects are don't-care; drive them to 0.
- FETCH: adrSrc 0, aluSrcA 00, aluSrcB 10, ADD, resultSrc 10.
  - irWriteEn and pcWriteEn are asserted only when i_memReady = 1.
  - While i_memReady = 0, stay in FETCH with all enables 0. Otherwise go to DECODE.
- DECODE: aluSrcA 01, aluSrcB 01, ADD (branch target). Next state by opcode:
  - lw/sw -> MEMADR
  - R -> EXEC_R
  - I-ALU -> EXEC_I
  - beq -> BEQ
  - jal -> JAL
  - anything else -> TRAP
- MEMADR: aluSrcA 10, aluSrcB 01, ADD. Next state: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: adrSrc 1, resultSrc 00. Hold while i_memReady = 0, then go to MEMWB.
- MEMWB: resultSrc 01, regWriteEn 1. Retires; next state FETCH.
- MEMWRITE: adrSrc 1, memWriteEn 1, held continuously while i_memReady = 0. Retires and goes to FETCH in the i_memReady = 1 cycle.
- EXEC_R: aluSrcA 10, aluSrcB 00, op = {i_funct7bit5, i_funct3}. Next state ALUWB.
- EXEC_I: aluSrcA 10, aluSrcB 01. op = {i_funct7bit5, i_funct3} when funct3 = 101, else {1'b0, i_funct3}. Next state ALUWB.
- ALUWB: resultSrc 00, regWriteEn 1. Retires; next state FETCH.
- BEQ: aluSrcA 10, aluSrcB 00, SUB, resultSrc 00, pcWriteEn = i_zero. Retires; next state FETCH.
- JAL: aluSrcA 01, aluSrcB 10, ADD, resultSrc 00, pcWriteEn 1. Retires; next state ALUWB. The ALUWB that follows does not retire again.
- TRAP: all enables 0, o_illegal = 1. Absorbing state; only reset exits.
- o_immSrc is decoded combinationally from i_opcode in every state: lw/I-ALU 000, sw 001, beq 010, jal 011, else 000.
- o_retired increments by exactly 1 per instruction, on the retiring edge. It wraps from all-ones to 0.
- Reset asserted mid-instruction aborts it with no further writes, and o_retired clears.

Test Plan:
- lw with i_memReady = 1 throughout -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles); regWriteEn high only in MEMWB with resultSrc 01; o_retired 0 -> 1.
- sw with i_memReady low for 3 cycles in MEMWRITE -> memWriteEn high for 4 consecutive cycles; exactly 1 retire; return to FETCH.
- add (funct7bit5 0, funct3 000) then sub (funct7bit5 1) -> aluLogicOperation 0000 then 1000 in EXEC_R; addi with funct7bit5 = 1 -> 0000; srai -> 1101.
- beq with i_zero = 1 -> pcWriteEn pulses once in BEQ; with i_zero = 0 -> no pcWriteEn outside FETCH; 3 cycles each.
- jal -> pcWriteEn in JAL, regWriteEn in ALUWB, o_retired +1 only; with ENABLE_JAL = 0 -> TRAP, o_illegal = 1, all enables 0 until reset.
- Opcode 7'b1111111 -> TRAP; assert i_arst mid-MEMWRITE -> memWriteEn drops immediately, o_retired = 0, FETCH after release; CNT_W = 4 preloaded to 15 via 15 retires, then one more -> 0.
